// File: rtl/subleq_pkg.sv
// subleq_pkg: shared word width and loader state encoding
package subleq_pkg;
    localparam int SUBLEQ_BITS = 8;
    typedef enum logic [1:0] {LOAD, RUN, DONE, ERROR} loader_state_t;
endpackage

// File: rtl/subleq_bus_mux.sv
// subleq_bus_mux: steers the RAM port between the loader and the core, owns core_data drive enable
module subleq_bus_mux
    import subleq_pkg::*;
#(
    parameter int BITS = SUBLEQ_BITS
) (
    input  loader_state_t   i_state,
    input  logic            i_core_reset,
    input  logic            i_load_we,
    input  logic [BITS-1:0] i_load_addr,
    input  logic [BITS-1:0] i_load_wdata,
    input  logic            i_core_write,
    input  logic [BITS-1:0] i_core_address,
    input  logic [BITS-1:0] i_core_data,
    output logic            o_mem_we,
    output logic [BITS-1:0] o_mem_addr,
    output logic [BITS-1:0] o_mem_wdata,
    output logic            o_core_drive
);
    logic w_pass;

    // Core owns the RAM port in RUN/DONE; a core still held in reset may not write
    always_comb begin
        w_pass       = (i_state == RUN) || (i_state == DONE);
        o_mem_we     = w_pass ? (i_core_write && !i_core_reset) : i_load_we;
        o_mem_addr   = w_pass ? i_core_address : i_load_addr;
        o_mem_wdata  = w_pass ? i_core_data : i_load_wdata;
        o_core_drive = w_pass && !i_core_write;
    end
endmodule

// File: rtl/subleq_loader.sv
// subleq_loader: streams a program into RAM, then hands the RAM port to the subleq core
module subleq_loader
    import subleq_pkg::*;
#(
    parameter int BITS = SUBLEQ_BITS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            core_reset,
    input  logic            core_halt,
    input  logic            core_write,
    input  logic [BITS-1:0] core_address,
    inout  wire  [BITS-1:0] core_data,
    output logic            mem_we,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    output logic            running,
    output logic            done,
    output logic            error,
    output logic [BITS:0]   words_loaded
);
    loader_state_t   r_state;
    loader_state_t   w_next;
    logic [BITS-1:0] r_load_addr;
    logic [BITS:0]   r_words_loaded;
    logic            r_core_reset;
    logic            w_accept;
    logic            w_core_drive;

    // State register; core reset drops on the same edge that enters RUN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= LOAD;
            r_core_reset <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_core_reset <= !((w_next == RUN) || (w_next == DONE));
        end
    end

    // Next state: finish on the last word, overflow into ERROR, halt ends RUN
    always_comb begin
        w_next = r_state;
        if (r_state == LOAD && w_accept)
            w_next = in_last ? RUN : (r_load_addr == '1) ? ERROR : LOAD;
        else if (r_state == RUN && core_halt)
            w_next = DONE;
    end

    // Outputs decoded from state; only LOAD accepts stream words
    always_comb begin
        in_ready = (r_state == LOAD);
        running  = (r_state == RUN);
        done     = (r_state == DONE);
        error    = (r_state == ERROR);
        w_accept = in_valid && in_ready;
    end

    // Load pointer and word count advance once per accepted word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_addr    <= '0;
            r_words_loaded <= '0;
        end else if (w_accept) begin
            r_load_addr    <= r_load_addr + 1'b1;
            r_words_loaded <= r_words_loaded + 1'b1;
        end
    end

    subleq_bus_mux #(.BITS(BITS)) u_mux (
        .i_state        (r_state),
        .i_core_reset   (r_core_reset),
        .i_load_we      (w_accept),
        .i_load_addr    (r_load_addr),
        .i_load_wdata   (in_data),
        .i_core_write   (core_write),
        .i_core_address (core_address),
        .i_core_data    (core_data),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_core_drive   (w_core_drive)
    );

    assign core_reset   = r_core_reset;
    assign words_loaded = r_words_loaded;
    assign core_data    = w_core_drive ? mem_rdata : 'z;
endmodule

// File: tb/tb_subleq_loader.sv
// tb_subleq_loader: scoreboarded check of program load, core passthrough, halt, reset and overflow
module tb_subleq_loader;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       core_reset;
    logic       core_halt;
    logic       core_write;
    logic [7:0] core_address;
    wire  [7:0] core_data;
    logic [7:0] core_drv;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       running;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sb[$];
    wr_t        e;
    logic [7:0] ram[256];
    logic [7:0] exp_addr;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clock = ~clock;

    subleq_loader #(.BITS(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .core_reset   (core_reset),
        .core_halt    (core_halt),
        .core_write   (core_write),
        .core_address (core_address),
        .core_data    (core_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .running      (running),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    assign core_data = core_write ? core_drv : 'z;
    assign mem_rdata = ram[mem_addr];

    always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        if (mem_we) begin
            if (sb.size() == 0) begin
                check("spurious_we", {31'b0, mem_we}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {24'b0, mem_addr}, {24'b0, e.a});
                check("wr_data", {24'b0, mem_wdata}, {24'b0, e.d});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        sb.push_back('{a: exp_addr, d: d});
        exp_addr = exp_addr + 8'd1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_gap();
        in_valid = 1'b0;
        in_last  = 1'b1;
        #1;
        check("gap_we", {31'b0, mem_we}, 32'd0);
        step();
        in_last = 1'b0;
    endtask

    task automatic core_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        core_write   = 1'b0;
        core_address = a;
        #1;
        check(tag, {24'b0, core_data}, {24'b0, exp});
    endtask

    task automatic core_store(input logic [7:0] a, input logic [7:0] d);
        core_write   = 1'b1;
        core_address = a;
        core_drv     = d;
        sb.push_back('{a: a, d: d});
        step();
        core_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        exp_addr = 8'd0;
    endtask

    task automatic halt_core();
        core_halt = 1'b1;
        for (int k = 0; k < 5 && !done; k++) step();
        core_halt = 1'b0;
        check("halt_done", {31'b0, done}, 32'd1);
        check("halt_running", {31'b0, running}, 32'd0);
    endtask

    initial begin
        logic [7:0] prog[9];
        prog = '{8'd3, 8'd4, 8'd6, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd6};
        for (int i = 0; i < 256; i++) ram[i] = 8'hee;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        core_halt = 1'b0; core_write = 1'b0; core_address = '0; core_drv = '0;
        exp_addr = 8'd0;
        step();
        do_reset();
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_core_reset", {31'b0, core_reset}, 32'd1);
        check("rst_flags", {29'b0, running, done, error}, 32'd0);
        check("rst_words", {23'b0, words_loaded}, 32'd0);

        send_word(8'h00, 1'b0);
        idle_gap();
        send_word(8'h00, 1'b0);
        idle_gap();
        check("mid_core_reset", {31'b0, core_reset}, 32'd1);
        send_word(8'h00, 1'b1);
        check("load3_core_reset", {31'b0, core_reset}, 32'd0);
        check("load3_running", {31'b0, running}, 32'd1);
        check("load3_ready", {31'b0, in_ready}, 32'd0);
        check("load3_words", {23'b0, words_loaded}, 32'd3);
        for (int i = 0; i < 3; i++) check("load3_ram", {24'b0, ram[i]}, 32'd0);
        check("load3_ram3_untouched", {24'b0, ram[3]}, 32'hee);
        core_read("run_read1", 8'd1, 8'h00);
        halt_core();

        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 20; i++) begin
            check("done_ready", {31'b0, in_ready}, 32'd0);
            check("done_stays", {31'b0, done}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        check("done_words", {23'b0, words_loaded}, 32'd3);

        do_reset();
        for (int i = 0; i < 9; i++) send_word(prog[i], i == 8);
        check("prog_words", {23'b0, words_loaded}, 32'd9);
        check("prog_running", {31'b0, running}, 32'd1);
        core_read("prog_rd_a", 8'd3, 8'd5);
        step();
        core_read("prog_rd_b", 8'd4, 8'd7);
        step();
        core_store(8'd4, 8'd2);
        core_read("prog_rd_b_new", 8'd4, 8'd2);
        core_read("prog_rd_loop", 8'd8, 8'd6);
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        exp_addr = 8'd0;
        check("mrst_core_reset", {31'b0, core_reset}, 32'd1);
        check("mrst_ready", {31'b0, in_ready}, 32'd1);
        check("mrst_running", {31'b0, running}, 32'd0);
        check("mrst_words", {23'b0, words_loaded}, 32'd0);
        send_word(8'd9, 1'b0);
        send_word(8'd8, 1'b1);
        check("reload_ram0", {24'b0, ram[0]}, 32'd9);
        check("reload_ram1", {24'b0, ram[1]}, 32'd8);
        check("reload_ram2_kept", {24'b0, ram[2]}, 32'd6);
        check("reload_ram4_kept", {24'b0, ram[4]}, 32'd2);
        check("reload_words", {23'b0, words_loaded}, 32'd2);
        halt_core();

        do_reset();
        for (int i = 0; i < 256; i++) send_word(8'(i) ^ 8'h5a, 1'b0);
        check("ovf_error", {31'b0, error}, 32'd1);
        check("ovf_core_reset", {31'b0, core_reset}, 32'd1);
        check("ovf_ready", {31'b0, in_ready}, 32'd0);
        check("ovf_words", {23'b0, words_loaded}, 32'd256);
        check("ovf_ram255", {24'b0, ram[255]}, 32'h5a ^ 32'hff);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        check("ovf_stays", {31'b0, error}, 32'd1);
        check("ovf_words_held", {23'b0, words_loaded}, 32'd256);
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
